// File: rtl/xf100_gnrl_fifo_pkg.sv
// xf100_gnrl_fifo_pkg: shared default sizing for the general-purpose FIFO
package xf100_gnrl_fifo_pkg;
    localparam int XF100_FIFO_DW = 32;
    localparam int XF100_FIFO_DP = 4;
endpackage

// File: rtl/xf100_gnrl_fifo_ent.sv
// xf100_gnrl_fifo_ent: one FIFO storage entry, a load-enabled register without reset
module xf100_gnrl_fifo_ent #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);
    always_ff @(posedge clk)
        if (en) q <= d;
endmodule

// File: rtl/xf100_gnrl_fifo.sv
// xf100_gnrl_fifo: valid/ready FIFO with registered-state handshakes and masked head data
module xf100_gnrl_fifo
    import xf100_gnrl_fifo_pkg::*;
#(
    parameter int DW = XF100_FIFO_DW,
    parameter int DP = XF100_FIFO_DP
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 i_vld,
    output logic                 i_rdy,
    input  logic [DW-1:0]        i_dat,
    output logic                 o_vld,
    input  logic                 o_rdy,
    output logic [DW-1:0]        o_dat,
    output logic [$clog2(DP):0]  cnt
);
    localparam int AW = $clog2(DP);
    logic [AW-1:0] wptr, rptr;
    logic [DW-1:0] ent_q [DP];
    logic          push, pop;
    assign i_rdy = cnt != (AW+1)'(DP);
    assign o_vld = cnt != '0;
    assign push  = i_vld & i_rdy & rst_n & ~flush;
    assign pop   = o_vld & o_rdy & rst_n & ~flush;
    // Stale entries stay in storage; only the head is exposed, and only while occupied
    assign o_dat = o_vld ? ent_q[rptr] : '0;
    for (genvar i = 0; i < DP; i++) begin : g_ent
        xf100_gnrl_fifo_ent #(.DW(DW)) u_ent (
            .clk (clk),
            .en  (push && wptr == AW'(i)),
            .d   (i_dat),
            .q   (ent_q[i])
        );
    end
    always_ff @(posedge clk)
        if (!rst_n || flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
endmodule

// File: tb/tb_xf100_gnrl_fifo.sv
// tb_xf100_gnrl_fifo: queue-model scoreboard with directed and random traffic
module tb_xf100_gnrl_fifo;
    localparam int DW = 32;
    localparam int DP = 4;
    logic clk = 0, rst_n = 0, flush = 0, i_vld = 0, o_rdy = 0;
    logic [DW-1:0] i_dat = '0;
    logic i_rdy, o_vld;
    logic [DW-1:0] o_dat;
    logic [$clog2(DP):0] cnt;
    int vectors = 0, errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] out_log[$];
    bit mon_en = 0;

    always #5 clk = ~clk;

    xf100_gnrl_fifo #(.DW(DW), .DP(DP)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .i_vld(i_vld), .i_rdy(i_rdy), .i_dat(i_dat),
        .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat), .cnt(cnt)
    );

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares outputs mid-cycle and retires the model head on each pop
    always @(negedge clk) if (mon_en) begin
        chk("cnt", DW'(cnt), DW'(exp_q.size()));
        chk("o_vld", DW'(o_vld), DW'(exp_q.size() != 0));
        chk("i_rdy", DW'(i_rdy), DW'(exp_q.size() != DP));
        chk("o_dat", o_dat, exp_q.size() != 0 ? exp_q[0] : '0);
        if (rst_n && !flush && o_rdy && exp_q.size() != 0) begin
            out_log.push_back(exp_q[0]);
            void'(exp_q.pop_front());
        end
    end

    // Stimulus: decides acceptance from model occupancy, enqueues expected data after the edge
    task automatic step(bit v, logic [DW-1:0] d, bit r, bit f = 0, bit rn = 1);
        bit acc;
        i_vld = v; i_dat = d; o_rdy = r; flush = f; rst_n = rn;
        acc = v && rn && !f && exp_q.size() != DP;
        @(posedge clk); #1;
        if (!rn || f) exp_q.delete();
        else if (acc) exp_q.push_back(d);
    endtask

    task automatic drain();
        for (int i = 0; i < DP + 1; i++) step(0, '0, 1);
    endtask

    initial begin
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        exp_q.delete();
        mon_en = 1;
        step(0, '0, 0);
        chk("reset_o_vld", DW'(o_vld), 0);
        chk("reset_i_rdy", DW'(i_rdy), 1);
        chk("reset_cnt", DW'(cnt), 0);
        chk("reset_o_dat", o_dat, 0);
        // Fill, overfill attempt, drain
        step(1, 32'h11, 0); step(1, 32'h22, 0); step(1, 32'h33, 0); step(1, 32'h44, 0);
        chk("full_cnt", DW'(cnt), 4);
        chk("full_i_rdy", DW'(i_rdy), 0);
        step(1, 32'h55, 0);
        chk("overfill_cnt", DW'(cnt), 4);
        out_log.delete();
        for (int i = 0; i < 4; i++) step(0, '0, 1);
        chk("drain_cnt", DW'(cnt), 0);
        chk("drain_n", DW'(out_log.size()), 4);
        for (int i = 0; i < 4; i++) chk("drain_order", out_log.size() > i ? out_log[i] : 'x, DW'(32'h11 * (i + 1)));
        // Simultaneous push/pop at two entries
        step(1, 32'h1, 0); step(1, 32'h2, 0);
        out_log.delete();
        step(1, 32'hAA, 1);
        chk("pp_cnt", DW'(cnt), 2);
        chk("pp_head", o_dat, 32'h2);
        drain();
        chk("pp_third", out_log.size() > 2 ? out_log[2] : 'x, 32'hAA);
        // Wrap-around through the pointers
        out_log.delete();
        for (int i = 0; i < 10; i++) step(1, DW'(i), 1);
        step(0, '0, 1);
        chk("wrap_n", DW'(out_log.size()), 10);
        for (int i = 0; i < 10; i++) chk("wrap_order", out_log.size() > i ? out_log[i] : 'x, DW'(i));
        // Push offered while full together with a pop
        for (int i = 0; i < 4; i++) step(1, DW'(32'hC0 + i), 0);
        step(1, 32'h77, 1);
        chk("fullpop_cnt", DW'(cnt), 3);
        chk("fullpop_i_rdy", DW'(i_rdy), 1);
        drain();
        // Flush with a push, then reset mid-operation
        for (int i = 0; i < 3; i++) step(1, DW'(32'hD0 + i), 0);
        step(1, 32'h99, 1, 1);
        chk("flush_cnt", DW'(cnt), 0);
        chk("flush_o_vld", DW'(o_vld), 0);
        step(1, 32'hE0, 0); step(1, 32'hE1, 0);
        chk("refill_cnt", DW'(cnt), 2);
        step(0, '0, 0, 0, 0);
        chk("rst_cnt", DW'(cnt), 0);
        chk("rst_o_dat", o_dat, 0);
        // Random traffic
        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
                 $urandom_range(0, 31) == 0, $urandom_range(0, 63) != 0);
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
